// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed RV32 data memory with a valid/ready request
// port and a fixed-latency response port. Handles LB/LH/LW/LBU/LHU/SB/SH/SW,
// access-fault detection and load sign/zero extension.
// Optional build macro: DMEM_PRELOAD_EN loads a power-up image at PRELOAD_OFFSET.
module data_mem_ctrl #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MEM_BYTES      = 32'h20000,
    parameter int READ_LATENCY   = 1,
    parameter int PRELOAD_OFFSET = 32'h10000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam logic [1:0] CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] load_data_q, load_data_d;

    logic [7:0]  mem [MEM_BYTES];

    logic                   accept;
    logic                   fault;
    logic                   f3_ok;
    logic                   misalign;
    logic [1:0]             size_m1;
    logic [ADDRESS_WIDTH:0] end_addr;
    logic [IDX_W-1:0]       idx [4];
    logic [7:0]             rd_byte [4];
    logic [3:0]             we_lane;
    logic [31:0]            ext_data;

    // Requests are taken only in IDLE and never while reset is held.
    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // Decode the request: access size, legality, lane indices and extended load data.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        size_m1  = 2'd0;
        ext_data = 32'd0;
        case (req_funct3[1:0])
            2'b01:   size_m1 = 2'd1;
            2'b10:   size_m1 = 2'd3;
            default: size_m1 = 2'd0;
        endcase
        if (req_we)
            f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        // One extra bit so the last-byte address cannot wrap past the top.
        end_addr = {1'b0, req_addr} + {{(ADDRESS_WIDTH-1){1'b0}}, size_m1};
        fault    = !f3_ok || misalign ||
                   (end_addr >= (ADDRESS_WIDTH+1)'(MEM_BYTES));
        for (int k = 0; k < 4; k++) begin
            idx[k]     = req_addr[IDX_W-1:0] + IDX_W'(k);
            rd_byte[k] = mem[idx[k]];
            we_lane[k] = accept && req_we && !fault && (2'(k) <= size_m1);
        end
        case (req_funct3)
            3'b000:  ext_data = {{24{rd_byte[0][7]}}, rd_byte[0]};
            3'b001:  ext_data = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            3'b010:  ext_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            3'b100:  ext_data = {24'd0, rd_byte[0]};
            3'b101:  ext_data = {16'd0, rd_byte[1], rd_byte[0]};
            default: ext_data = 32'd0;
        endcase
        if (fault || req_we)
            ext_data = 32'd0;
    end

    // Store lanes commit on the acceptance edge, so a following load sees them.
    // NOTE: the byte array has no reset; only control state is reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_lane[k])
                mem[idx[k]] <= req_wdata[8*k +: 8];
        end
    end

`ifdef DMEM_PRELOAD_EN
    // Power-up image; reset leaves the array untouched.
    localparam logic [7:0] PRELOAD_IMAGE [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    initial begin
        for (int k = 0; k < 4; k++)
            mem[IDX_W'(PRELOAD_OFFSET + k)] = PRELOAD_IMAGE[k];
    end
`else
    // No preload: contents stay unknown until written.
    logic unused_preload;
    assign unused_preload = ^PRELOAD_OFFSET;
`endif

    // Next-state logic for the IDLE -> (WAIT) -> RESP sequence and its registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_data_d = ext_data;
                    if ((READ_LATENCY > 1) && !req_we && !fault) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = fault;
                        rsp_rdata_d = ext_data;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_data_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any pending response.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            load_data_q <= load_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: instance A uses READ_LATENCY=1, instance B
// READ_LATENCY=3. Expected responses go through a scoreboard queue.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic        va, wea, rdya, rva, erra;
    logic [2:0]  f3a;
    logic [31:0] addra, wda, rda;
    logic        vb, web, rdyb, rvb, errb;
    logic [2:0]  f3b;
    logic [31:0] addrb, wdb, rdb;

    data_mem_ctrl #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .req_valid(va), .req_ready(rdya), .req_we(wea),
        .req_funct3(f3a), .req_addr(addra), .req_wdata(wda),
        .rsp_valid(rva), .rsp_rdata(rda), .rsp_err(erra)
    );

    data_mem_ctrl #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .req_valid(vb), .req_ready(rdyb), .req_we(web),
        .req_funct3(f3b), .req_addr(addrb), .req_wdata(wdb),
        .rsp_valid(rvb), .rsp_rdata(rdb), .rsp_err(errb)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   sel_b  = 1'b0;

    logic        m_ready, m_rvalid, m_err;
    logic [31:0] m_rdata;
    assign m_ready  = sel_b ? rdyb : rdya;
    assign m_rvalid = sel_b ? rvb  : rva;
    assign m_err    = sel_b ? errb : erra;
    assign m_rdata  = sel_b ? rdb  : rda;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (b) begin
            vb = v; web = we; f3b = f3; addrb = a; wdb = wd;
        end else begin
            va = v; wea = we; f3a = f3; addra = a; wda = wd;
        end
    endtask

    // One request: push the expectation, wait (bounded) for the response, pop and compare.
    task automatic do_req(input string tag, input bit b, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        bit   got;
        sel_b = b;
        @(negedge clk);
        check({tag, ":ready"}, 32'(m_ready), 32'd1);
        drive(b, 1'b1, we, f3, a, wd);
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = (we || exp_err) ? 1 : (b ? 3 : 1);
        sb_q.push_back(e);
        @(posedge clk);
        #1 drive(b, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (m_rvalid) got = 1'b1;
        end
        e = sb_q.pop_front();
        check({tag, ":lat"}, 32'(n), 32'(e.lat));
        check({tag, ":rdata"}, m_rdata, e.rdata);
        check({tag, ":err"}, 32'(m_err), 32'(e.err));
        @(negedge clk);
        check({tag, ":pulse"}, 32'(m_rvalid), 32'd0);
        check({tag, ":ready_back"}, 32'(m_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_a:rvalid", 32'(rva), 32'd0);
        check("rst_a:rdata", rda, 32'd0);
        check("rst_a:err", 32'(erra), 32'd0);
        check("rst_b:rvalid", 32'(rvb), 32'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
        check("rst_a:ready", 32'(rdya), 32'd1);
        check("rst_b:ready", 32'(rdyb), 32'd1);

        // Widths and extension on the single-cycle instance.
        do_req("sw_100",   1'b0, 1'b1, 3'b010, 32'h100, 32'h8000_00FF, 32'h0, 1'b0);
        do_req("lw_100",   1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8000_00FF, 1'b0);
        do_req("lb_100",   1'b0, 1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b0);
        do_req("lbu_100",  1'b0, 1'b0, 3'b100, 32'h100, 32'h0, 32'h0000_00FF, 1'b0);
        do_req("lh_102",   1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_8000, 1'b0);
        do_req("lhu_102",  1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 32'h0000_8000, 1'b0);
        do_req("sb_101",   1'b0, 1'b1, 3'b000, 32'h101, 32'h1234_56AA, 32'h0, 1'b0);
        do_req("lw_after_sb", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8000_AAFF, 1'b0);
        do_req("lbu_100b", 1'b0, 1'b0, 3'b100, 32'h100, 32'h0, 32'h0000_00FF, 1'b0);
        do_req("lbu_102",  1'b0, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0000_0000, 1'b0);
        do_req("lbu_103",  1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0080, 1'b0);

        // Faults: misalignment, illegal funct3, out of range; none may write.
        do_req("f_lw_102",  1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1);
        do_req("f_sh_101",  1'b0, 1'b1, 3'b001, 32'h101, 32'h0000_FFFF, 32'h0, 1'b1);
        do_req("f_lhu_101", 1'b0, 1'b0, 3'b101, 32'h101, 32'h0, 32'h0, 1'b1);
        do_req("f_ld_011",  1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1);
        do_req("f_st_100",  1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1);
        do_req("lw_nomod",  1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8000_AAFF, 1'b0);
        do_req("sw_top",    1'b0, 1'b1, 3'b010, 32'h1FFFC, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_req("lb_last",   1'b0, 1'b0, 3'b000, 32'h1FFFF, 32'h0, 32'hFFFF_FFCA, 1'b0);
        do_req("f_lw_1fffe", 1'b0, 1'b0, 3'b010, 32'h1FFFE, 32'h0, 32'h0, 1'b1);
        do_req("f_sw_1fffe", 1'b0, 1'b1, 3'b010, 32'h1FFFE, 32'h1111_1111, 32'h0, 1'b1);
        do_req("f_lb_oob",  1'b0, 1'b0, 3'b000, 32'h20000, 32'h0, 32'h0, 1'b1);
        do_req("lw_top_nomod", 1'b0, 1'b0, 3'b010, 32'h1FFFC, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Three-cycle instance: latency per request type.
        do_req("b_sw_200", 1'b1, 1'b1, 3'b010, 32'h200, 32'h1234_5678, 32'h0, 1'b0);
        do_req("b_lw_200", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 1'b0);
        do_req("b_lh_202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h0000_1234, 1'b0);
        do_req("b_lb_203", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h0000_0012, 1'b0);
        do_req("b_f_lw_201", 1'b1, 1'b0, 3'b010, 32'h201, 32'h0, 32'h0, 1'b1);

        // req_valid held high: accepts 4 cycles apart, response 3 cycles after each.
        sel_b = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("held:ready_%0d", i), 32'(rdyb), 32'((i % 4) == 0));
            check($sformatf("held:rvalid_%0d", i), 32'(rvb), 32'((i % 4) == 3));
            if (rdyb) begin
                e.rdata = 32'h1234_5678;
                e.err   = 1'b0;
                e.lat   = 3;
                sb_q.push_back(e);
            end
            if (rvb && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("held:rdata_%0d", i), rdb, e.rdata);
            end
            @(negedge clk);
        end
        check("held:ready_12", 32'(rdyb), 32'd1);
        sb_q.delete();

        // Reset while WAITing: the response is dropped.
        @(negedge clk);
        check("rstwait:in_wait", 32'(rdyb), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst_b_n = 1'b0;
        #1;
        check("rstwait:rvalid", 32'(rvb), 32'd0);
        check("rstwait:rdata", rdb, 32'd0);
        check("rstwait:err", 32'(errb), 32'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rstwait:no_rsp_%0d", i), 32'(rvb), 32'd0);
        end

        // Reset right after a store acceptance: store stays committed, no response.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF);
        @(posedge clk);
        #1 rst_b_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1 check("rststore:rvalid", 32'(rvb), 32'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        check("rststore:no_rsp", 32'(rvb), 32'd0);
        do_req("b_lw_300", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0);

`ifdef DMEM_PRELOAD_EN
        do_req("preload_lw", 1'b0, 1'b0, 3'b010, 32'h10000, 32'h0, 32'h4433_2211, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
